// File: rtl/m_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package m_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    // Divide-class ops (DIV/DIVU/REM/REMU) have func3[2] set.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/m_unit_controller_special.sv
// Combinational detection of M-extension ops whose result is known without a unit.
module m_special_case
    import m_unit_pkg::*;
#(
    parameter int ZERO_SHORTCUT = 1
) (
    input  logic [2:0]  func3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        is_special,
    output logic [31:0] special_result
);

    always_comb begin
        is_special     = 1'b0;
        special_result = '0;
        if (!is_div_op(func3)) begin
            if ((ZERO_SHORTCUT != 0) && ((op1 == '0) || (op2 == '0))) begin
                is_special = 1'b1;
            end
        end else if (op2 == '0) begin
            // Division by zero takes precedence over the zero-dividend shortcut.
            is_special     = 1'b1;
            special_result = func3[1] ? op1 : DIV_BY_ZERO_Q;
        end else if (!func3[0] && (op1 == INT_MIN) && (op2 == '1)) begin
            is_special     = 1'b1;
            special_result = func3[1] ? 32'h0 : INT_MIN;
        end else if ((ZERO_SHORTCUT != 0) && (op1 == '0)) begin
            is_special = 1'b1;
        end
    end

endmodule

// File: rtl/m_unit_controller.sv
// Sequences RV32M ops onto an external multiplier / iterative divider and
// returns a one-cycle result group that overrides the ALU writeback.
module m_unit_controller
    import m_unit_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ZERO_SHORTCUT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_m,
    input  logic [2:0]        ex_func3,
    input  logic [XLEN-1:0]   ex_op1,
    input  logic [XLEN-1:0]   ex_op2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_wb_reg_file,
    input  logic              pipeline_flush,
    output logic              mul_start,
    output logic [1:0]        mul_op,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    input  logic              mul_done,
    input  logic [2*XLEN-1:0] mul_product,
    output logic              div_start,
    output logic              div_signed,
    output logic [XLEN-1:0]   div_dividend,
    output logic [XLEN-1:0]   div_divisor,
    input  logic              div_done,
    input  logic [XLEN-1:0]   div_quotient,
    input  logic [XLEN-1:0]   div_remainder,
    output logic              unit_abort,
    output logic              m_unit_stall,
    output logic              m_unit_ready,
    output logic [XLEN-1:0]   m_unit_result,
    output logic              m_unit_wr,
    output logic [4:0]        m_unit_dest,
    output logic              busy
);

    state_t          state_reg, state_next;
    logic [2:0]      func3_reg;
    logic [XLEN-1:0] op1_reg, op2_reg, result_reg, result_next;
    logic [4:0]      rd_reg;
    logic            wb_reg;
    logic            mul_start_reg, mul_start_next;
    logic            div_start_reg, div_start_next;
    logic            result_load;
    logic            accept;
    logic            in_wait;
    logic            in_done;
    logic            is_special;
    logic [XLEN-1:0] special_result;

    m_special_case #(
        .ZERO_SHORTCUT (ZERO_SHORTCUT)
    ) u_special (
        .func3          (ex_func3),
        .op1            (ex_op1),
        .op2            (ex_op2),
        .is_special     (is_special),
        .special_result (special_result)
    );

    // rst_n gates accept so stall stays low while reset is held.
    assign accept  = rst_n && (state_reg == ST_IDLE) && ex_valid_m && !pipeline_flush;
    assign in_wait = (state_reg == ST_MUL_WAIT) || (state_reg == ST_DIV_WAIT);
    assign in_done = (state_reg == ST_DONE);

    always_comb begin
        state_next     = state_reg;
        mul_start_next = 1'b0;
        div_start_next = 1'b0;
        result_load    = 1'b0;
        result_next    = result_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (is_special) begin
                        state_next  = ST_DONE;
                        result_load = 1'b1;
                        result_next = special_result;
                    end else if (!is_div_op(ex_func3)) begin
                        state_next     = ST_MUL_WAIT;
                        mul_start_next = 1'b1;
                    end else begin
                        state_next     = ST_DIV_WAIT;
                        div_start_next = 1'b1;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (pipeline_flush) begin
                    state_next = ST_IDLE;
                end else if (mul_done) begin
                    state_next  = ST_DONE;
                    result_load = 1'b1;
                    result_next = (func3_reg[1:0] == 2'b00) ? mul_product[XLEN-1:0]
                                                            : mul_product[2*XLEN-1:XLEN];
                end
            end
            ST_DIV_WAIT: begin
                if (pipeline_flush) begin
                    state_next = ST_IDLE;
                end else if (div_done) begin
                    state_next  = ST_DONE;
                    result_load = 1'b1;
                    result_next = func3_reg[1] ? div_remainder : div_quotient;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            func3_reg     <= '0;
            op1_reg       <= '0;
            op2_reg       <= '0;
            rd_reg        <= '0;
            wb_reg        <= 1'b0;
            result_reg    <= '0;
            mul_start_reg <= 1'b0;
            div_start_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mul_start_reg <= mul_start_next;
            div_start_reg <= div_start_next;
            if (accept) begin
                func3_reg <= ex_func3;
                op1_reg   <= ex_op1;
                op2_reg   <= ex_op2;
                rd_reg    <= ex_rd;
                wb_reg    <= ex_wb_reg_file;
            end
            if (result_load) begin
                result_reg <= result_next;
            end
        end
    end

    assign mul_start    = mul_start_reg;
    assign mul_op       = func3_reg[1:0];
    assign mul_a        = op1_reg;
    assign mul_b        = op2_reg;
    assign div_start    = div_start_reg;
    // Qualified by func3[2] so it reads 0 out of reset instead of "signed".
    assign div_signed   = func3_reg[2] & ~func3_reg[0];
    assign div_dividend = op1_reg;
    assign div_divisor  = op2_reg;

    assign unit_abort    = in_wait && pipeline_flush;
    assign m_unit_stall  = accept || in_wait;
    assign m_unit_ready  = in_done && !pipeline_flush;
    assign m_unit_wr     = m_unit_ready && wb_reg;
    assign m_unit_dest   = in_done ? rd_reg : '0;
    assign m_unit_result = in_done ? result_reg : '0;
    assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_m_unit_controller.sv
// Self-checking bench for m_unit_controller with behavioural multiplier/divider stubs.
module tb_m_unit_controller;
    import m_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_m;
    logic [2:0]  ex_func3;
    logic [31:0] ex_op1, ex_op2;
    logic [4:0]  ex_rd;
    logic        ex_wb_reg_file;
    logic        pipeline_flush;
    logic        mul_start;
    logic [1:0]  mul_op;
    logic [31:0] mul_a, mul_b;
    logic        mul_done;
    logic [63:0] mul_product;
    logic        div_start, div_signed;
    logic [31:0] div_dividend, div_divisor;
    logic        div_done;
    logic [31:0] div_quotient, div_remainder;
    logic        unit_abort, m_unit_stall, m_unit_ready, m_unit_wr, busy;
    logic [31:0] m_unit_result;
    logic [4:0]  m_unit_dest;

    m_unit_controller #(.XLEN(32), .ZERO_SHORTCUT(1)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid_m(ex_valid_m), .ex_func3(ex_func3),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_wb_reg_file(ex_wb_reg_file),
        .pipeline_flush(pipeline_flush), .mul_start(mul_start), .mul_op(mul_op),
        .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_product(mul_product),
        .div_start(div_start), .div_signed(div_signed), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_done(div_done), .div_quotient(div_quotient),
        .div_remainder(div_remainder), .unit_abort(unit_abort), .m_unit_stall(m_unit_stall),
        .m_unit_ready(m_unit_ready), .m_unit_result(m_unit_result), .m_unit_wr(m_unit_wr),
        .m_unit_dest(m_unit_dest), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wb;
        logic [31:0] res;
        int          lat;   // cycles from accept to ready
        int          kind;  // 0 none, 1 multiplier, 2 divider
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mul_starts = 0;
    int   div_starts = 0;
    bit   ready_seen = 1'b0;
    vec_t vecs[16];

    // Multiplier stub: done two cycles after the start cycle.
    initial begin : mul_model
        int          cnt;
        logic [63:0] pend, a64, b64;
        cnt = 0; pend = '0;
        mul_done = 1'b0; mul_product = '0;
        forever begin
            @(negedge clk); #1;
            mul_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mul_done    = 1'b1;
                    mul_product = pend;
                end
            end
            if (mul_start) begin
                a64  = (mul_op == 2'b11) ? {32'h0, mul_a} : {{32{mul_a[31]}}, mul_a};
                b64  = mul_op[1] ? {32'h0, mul_b} : {{32{mul_b[31]}}, mul_b};
                pend = a64 * b64;
                cnt  = 2;
            end
        end
    end

    // Divider stub: done 32 cycles after the start cycle; ignores abort so late dones occur.
    initial begin : div_model
        int          cnt;
        logic [31:0] q, r;
        cnt = 0; q = '0; r = '0;
        div_done = 1'b0; div_quotient = '0; div_remainder = '0;
        forever begin
            @(negedge clk); #1;
            div_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    div_done      = 1'b1;
                    div_quotient  = q;
                    div_remainder = r;
                end
            end
            if (div_start) begin
                if (div_divisor == '0) begin
                    q = '1; r = div_dividend;
                end else if (div_signed) begin
                    q = 32'($signed(div_dividend) / $signed(div_divisor));
                    r = 32'($signed(div_dividend) % $signed(div_divisor));
                end else begin
                    q = div_dividend / div_divisor;
                    r = div_dividend % div_divisor;
                end
                cnt = 32;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one cycle and score any result group presented by the DUT.
    task automatic tick();
        exp_t e;
        @(negedge clk); #1;
        if (mul_start) mul_starts++;
        if (div_start) div_starts++;
        ready_seen = m_unit_ready;
        if (m_unit_ready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_ready: got result 0x%08h rd=%0d, expected no result",
                         m_unit_result, m_unit_dest);
            end else begin
                e = sb.pop_front();
                check("result", 64'(m_unit_result), 64'(e.res));
                check("dest",   64'(m_unit_dest),   64'(e.rd));
                check("wr",     64'(m_unit_wr),     64'(e.wr));
            end
        end
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic wb);
        ex_func3 = f3; ex_op1 = a; ex_op2 = b; ex_rd = rd; ex_wb_reg_file = wb;
        ex_valid_m = 1'b1;
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [4:0] rd, input logic wr);
        exp_t e;
        e.res = res; e.rd = rd; e.wr = wr;
        sb.push_back(e);
    endtask

    task automatic run_op(input vec_t v);
        int n, ms0, ds0;
        ms0 = mul_starts; ds0 = div_starts;
        drive_op(v.f3, v.a, v.b, v.rd, v.wb);
        push_exp(v.res, v.rd, v.wb);
        #1;
        check("stall_accept", 64'(m_unit_stall), 64'(1));
        n = 0;
        do begin
            tick();
            n++;
            ex_valid_m = 1'b0;
            check("stall", 64'(m_unit_stall), 64'(!ready_seen));
        end while (!ready_seen && n < 60);
        if (!ready_seen) sb.delete();
        check("latency",    64'(n), 64'(v.lat));
        check("mul_launch", 64'(mul_starts - ms0), 64'(v.kind == 1));
        check("div_launch", 64'(div_starts - ds0), 64'(v.kind == 2));
        $display("txn f3=%0d a=0x%08h b=0x%08h rd=%0d -> expected 0x%08h after %0d cycles",
                 v.f3, v.a, v.b, v.rd, v.res, v.lat);
        tick();
        check("idle_after", 64'(busy), 64'(0));
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n, ms0, ds0;
        vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  1'b1, 32'hFFFF_FFEB, 4,  1};
        vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  1'b1, 32'hFFFF_FFFE, 4,  1};
        vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  1'b1, 32'h0000_0000, 4,  1};
        vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFE,  32'd3,         5'd8,  1'b1, 32'hFFFF_FFFF, 4,  1};
        vecs[4]  = '{F3_MUL,    32'd0,          32'd5,         5'd9,  1'b1, 32'h0000_0000, 1,  0};
        vecs[5]  = '{F3_DIV,    32'd100,        32'd0,         5'd10, 1'b1, 32'hFFFF_FFFF, 1,  0};
        vecs[6]  = '{F3_REMU,   32'd100,        32'd0,         5'd11, 1'b1, 32'd100,       1,  0};
        vecs[7]  = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 1'b1, 32'h8000_0000, 1,  0};
        vecs[8]  = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 1'b1, 32'h0000_0000, 1,  0};
        vecs[9]  = '{F3_DIVU,   32'd1000,       32'd7,         5'd14, 1'b1, 32'd142,       34, 2};
        vecs[10] = '{F3_REMU,   32'd1000,       32'd7,         5'd15, 1'b1, 32'd6,         34, 2};
        vecs[11] = '{F3_DIV,    32'hFFFF_FFEC,  32'd3,         5'd16, 1'b1, 32'hFFFF_FFFA, 34, 2};
        vecs[12] = '{F3_REM,    32'hFFFF_FFEC,  32'd3,         5'd17, 1'b1, 32'hFFFF_FFFE, 34, 2};
        vecs[13] = '{F3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 1'b1, 32'h0000_0000, 34, 2};
        vecs[14] = '{F3_DIV,    32'd0,          32'd5,         5'd19, 1'b1, 32'h0000_0000, 1,  0};
        vecs[15] = '{F3_MULHU,  32'd3,          32'd4,         5'd20, 1'b0, 32'h0000_0000, 4,  1};

        rst_n = 1'b0; pipeline_flush = 1'b0;
        drive_op(F3_MUL, 32'd3, 32'd3, 5'd1, 1'b1);   // valid op held during reset
        tick(); tick();
        check("reset_outputs", 64'(|{mul_start, mul_op, mul_a, mul_b, div_start, div_signed,
                                     div_dividend, div_divisor, unit_abort, m_unit_stall,
                                     m_unit_ready, m_unit_result, m_unit_wr, m_unit_dest}), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        ex_valid_m = 1'b0;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i]);
        end

        // Flush during DIV_WAIT: abort pulse, no result, late done ignored.
        ds0 = div_starts;
        drive_op(F3_DIVU, 32'd1000, 32'd7, 5'd4, 1'b1);
        tick();
        ex_valid_m = 1'b0;
        check("flush_div_launched", 64'(div_starts - ds0), 64'(1));
        tick(); tick(); tick();
        pipeline_flush = 1'b1;
        #1;
        check("flush_abort", 64'(unit_abort), 64'(1));
        tick();
        pipeline_flush = 1'b0;
        #1;
        check("flush_idle", 64'(busy), 64'(0));
        check("flush_abort_end", 64'(unit_abort), 64'(0));
        repeat (40) tick();
        $display("txn flushed DIVU in DIV_WAIT, no result expected");
        run_op(vecs[0]);

        // Flush in DONE suppresses ready and wr.
        drive_op(F3_DIV, 32'd5, 32'd0, 5'd21, 1'b1);
        @(negedge clk);
        pipeline_flush = 1'b1;
        ex_valid_m = 1'b0;
        #1;
        check("done_flush_ready", 64'(m_unit_ready), 64'(0));
        check("done_flush_wr", 64'(m_unit_wr), 64'(0));
        check("done_flush_busy", 64'(busy), 64'(1));
        pipeline_flush = 1'b0;
        tick();
        check("done_flush_idle", 64'(busy), 64'(0));
        $display("txn flushed DIV in DONE, no result expected");

        // Reset in MUL_WAIT discards the op.
        drive_op(F3_MUL, 32'd6, 32'd7, 5'd22, 1'b1);
        tick();
        check("rst_mid_in_wait", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 64'(|{mul_start, mul_op, mul_a, mul_b, div_start, div_signed,
                                       div_dividend, div_divisor, unit_abort, m_unit_stall,
                                       m_unit_ready, m_unit_result, m_unit_wr, m_unit_dest,
                                       busy}), 64'(0));
        tick(); tick();
        ex_valid_m = 1'b0;
        rst_n = 1'b1;
        repeat (6) tick();
        check("rst_mid_idle", 64'(busy), 64'(0));
        $display("txn reset in MUL_WAIT, no result expected");

        // Back-to-back: MUL presented during DONE starts only after IDLE.
        drive_op(F3_DIV, 32'd100, 32'd0, 5'd23, 1'b1);
        push_exp(32'hFFFF_FFFF, 5'd23, 1'b1);
        tick();
        check("b2b_first_ready", 64'(ready_seen), 64'(1));
        ms0 = mul_starts;
        drive_op(F3_MUL, 32'd3, 32'd5, 5'd24, 1'b1);
        push_exp(32'd15, 5'd24, 1'b1);
        #1;
        check("b2b_stall_in_done", 64'(m_unit_stall), 64'(0));
        tick();
        check("b2b_no_restart", 64'(mul_starts - ms0), 64'(0));
        check("b2b_accept_stall", 64'(m_unit_stall), 64'(1));
        tick();
        ex_valid_m = 1'b0;
        check("b2b_mul_start", 64'(mul_starts - ms0), 64'(1));
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready_seen && n < 60);
        check("b2b_latency", 64'(n), 64'(3));
        check("b2b_drained", 64'(sb.size()), 64'(0));
        $display("txn back-to-back DIV/0 then MUL 3*5 -> 0x0000000f");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m_unit_controller.md
Name: m_unit_controller

Overview:
Sequencer for the RV32M multiply/divide resource feeding the execute stage.
- Accepts an M-extension op from EX and launches either the external multiplier or the iterative divider through start/done handshakes.
- Resolves RISC-V divide special cases itself, without using the divider.
- Stalls the pipeline while busy, then returns the result as a one-cycle m_unit_ready/m_unit_result/m_unit_wr/m_unit_dest group that overrides the ALU writeback.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
ZERO_SHORTCUT, 1, when 1: MUL* with a zero operand and DIV/REM with a zero dividend complete without launching a unit

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ex_valid_m  in  1  EX holds a valid M-extension op (OP opcode, func7=0000001)
ex_func3  in  3  M op select
ex_op1  in  32  forwarded rs1 value
ex_op2  in  32  forwarded rs2 value
ex_rd  in  5  destination register
ex_wb_reg_file  in  1  op writes the register file
pipeline_flush  in  1  flush of the EX stage
mul_start  out  1  one-cycle launch pulse to the multiplier
mul_op  out  2  func3[1:0] held to the multiplier (signedness select)
mul_a, mul_b  out  32 each  latched operands
mul_done  in  1  product valid
mul_product  in  64  full product
div_start  out  1  one-cycle launch pulse to the divider
div_signed  out  1  signed divide
div_dividend, div_divisor  out  32 each  latched operands
div_done  in  1  quotient/remainder valid
div_quotient, div_remainder  in  32 each  divider results
unit_abort  out  1  one-cycle kill pulse to both units
m_unit_stall  out  1  hold IF/ID/EX
m_unit_ready  out  1  result valid this cycle
m_unit_result  out  32  result
m_unit_wr  out  1  register-file write enable
m_unit_dest  out  5  destination register
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE. Every output and every latched register is 0, and this holds while rst_n=0.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- Accept:
  - In IDLE, an op is accepted in cycle T when ex_valid_m=1 and pipeline_flush=0.
  - On accept, latch func3, op1, op2, rd and ex_wb_reg_file.
  - ex_valid_m in any state other than IDLE is ignored.
- Stall: m_unit_stall = (IDLE & ex_valid_m & ~pipeline_flush) | MUL_WAIT | DIV_WAIT. It is combinational and is 0 in DONE, so the stalled op leaves EX carrying the result.
- Routing on accept:
  - Special case → DONE at T+1. The result register is loaded at accept.
  - func3[2]=0 → MUL_WAIT; mul_start pulses at T+1.
  - Otherwise → DIV_WAIT; div_start pulses at T+1.
  - Operands and mul_op/div_signed remain stable until the state leaves WAIT.
- Special cases:
  - Divisor=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
  - With ZERO_SHORTCUT=1: zero shortcuts → 0.
- Completion:
  - Units never assert done in their start cycle. done is sampled only in the matching WAIT state.
  - The done cycle registers the result and moves to DONE.
  - MUL result = product[31:0]. MULH/MULHSU/MULHU result = product[63:32].
  - DIV/DIVU result = quotient. REM/REMU result = remainder.
- DONE lasts exactly one cycle:
  - m_unit_ready=1; m_unit_result, m_unit_dest and m_unit_wr are driven from the latches.
  - Then → IDLE.
  - Outside DONE: ready, wr, dest and result are all 0.
- Latency: result in DONE at T+k+1 for a unit with done at T+k; T+1 for special cases.
- Flush:
  - In MUL_WAIT or DIV_WAIT: unit_abort pulses in the same cycle, state → IDLE next cycle, no ready is produced.
  - A done arriving in or after the abort cycle is ignored.
  - Flush in DONE: m_unit_ready and m_unit_wr are forced to 0.
- A stray mul_done or div_done outside its WAIT state is ignored.
- A reset assertion mid-operation discards the op. No ready is produced after release.

Decomposition:
- Package m_unit_pkg holds:
  - the state enum;
  - func3 constants MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111;
  - DIV_BY_ZERO_Q=32'hFFFFFFFF and INT_MIN=32'h80000000.
- One combinational sub-module, m_special_case, takes func3, op1 and op2 and produces is_special and special_result.

Test Plan:
1. MUL 7 × 0xFFFFFFFD with a multiplier model of done at T+3 → mul_start at T+1; m_unit_stall high T..T+3; m_unit_ready at T+4 with result 0xFFFFFFEB, dest=rd, wr=1.
2. MULHU 0xFFFFFFFF × 0xFFFFFFFF → result 0xFFFFFFFE. MULH of the same operands → 0x00000000.
3. DIV 100/0 → no div_start, ready at T+1, result 0xFFFFFFFF. REMU 100/0 → 100.
4. DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000. REM of the same operands → 0. Neither launches the divider.
5. DIVU 1000/7 with a divider model of done at T+33 → result 142; REMU → 6. A flush in DIV_WAIT instead → unit_abort pulse, no ready, and a late div_done is ignored. A following MUL is then accepted normally.
6. Assert rst_n=0 in MUL_WAIT → all outputs 0 immediately. A back-to-back MUL presented in the DONE cycle is not restarted; it is accepted only after IDLE.
